// File: rtl/fu_result_pkg.sv
// fu_result_pkg
//   Shared types for functional-unit result transport. The writeback
//   arbiter, the writeback stage and fu_result_queue all import this
//   package so that a result has one agreed layout.
//
//   FU_DATA_W   : default result data width
//   FU_TAG_W    : default destination/ROB tag width
//   fu_result_t : packed {data, tag} pair held in each queue entry
package fu_result_pkg;

    localparam int FU_DATA_W = 32;
    localparam int FU_TAG_W  = 6;

    typedef struct packed {
        logic [FU_DATA_W-1:0] data;
        logic [FU_TAG_W-1:0]  tag;
    } fu_result_t;

endpackage

// File: rtl/fu_result_queue.sv
// fu_result_queue
//   Requester-side result buffer placed at the output of one functional
//   unit. Completed results are queued in strict FIFO order and offered to
//   the writeback arbiter; an entry drains on a cycle where is_req is high
//   and stall is low.
//
//   Optional feature macro: FU_RESULT_QUEUE_BYPASS_EN
//     When defined and the queue is empty, an incoming result is presented
//     to the arbiter combinationally in the same cycle and is only written
//     into the queue if the arbiter stalls. Undefined (default): is_req and
//     out_* come purely from registered state.
//
//   Parameters
//     DATA_W : result data width (must match fu_result_pkg::FU_DATA_W)
//     TAG_W  : result tag width  (must match fu_result_pkg::FU_TAG_W)
//     DEPTH  : entry count, power of two, >= 2
//   Ports
//     clk      in  : clock, rising edge
//     rst      in  : asynchronous active-high reset
//     flush    in  : discard all entries on the next edge
//     in_valid in  : functional unit offers a result
//     in_data  in  : result value
//     in_tag   in  : result tag
//     in_ready out : a push is accepted this cycle
//     is_req   out : request to the writeback arbiter (head valid)
//     out_data out : head result value
//     out_tag  out : head result tag
//     stall    in  : arbiter denies the request this cycle
module fu_result_queue
    import fu_result_pkg::*;
#(
    parameter int DATA_W = FU_DATA_W,
    parameter int TAG_W  = FU_TAG_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              in_ready,
    output logic              is_req,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fu_result_t       mem [DEPTH];
    fu_result_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass_take;

    always_comb begin
        empty    = (count == '0);
        // Readiness depends only on registered count: a pop in the same
        // cycle as a full queue does not open the input.
        in_ready = (count != FULL_CNT);
        head     = mem[rd_ptr];
        pop      = !empty && !stall && !flush;
`ifdef FU_RESULT_QUEUE_BYPASS_EN
        is_req      = !empty || (in_valid && !flush);
        // Empty queue and an immediate grant: the result leaves straight
        // from the inputs and never occupies an entry.
        bypass_take = empty && in_valid && !flush && !stall;
        out_data    = empty ? in_data : head.data;
        out_tag     = empty ? in_tag  : head.tag;
`else
        is_req      = !empty;
        bypass_take = 1'b0;
        out_data    = head.data;
        out_tag     = head.tag;
`endif
        push = in_valid && in_ready && !flush && !bypass_take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: in_data, tag: in_tag};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_result_queue.sv
module tb_fu_result_queue;
    import fu_result_pkg::*;

    localparam int DW = 32;
    localparam int TW = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [TW-1:0] in_tag;
    logic          in_ready;
    logic          is_req;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          stall;

    int checks = 0;
    int fails  = 0;

    fu_result_t sbq[$];

    fu_result_queue #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .in_ready (in_ready),
        .is_req   (is_req),
        .out_data (out_data),
        .out_tag  (out_tag),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [TW-1:0] t);
        return 32'hA5C3_0000 | {26'd0, t} | ({26'd0, t} << 8);
    endfunction

    // Monitor: pops the scoreboard on every grant and checks the head.
    // Also checks that a stalled head holds stable until its grant.
    logic          hold_prev = 1'b0;
    logic [TW-1:0] hold_tag;
    logic [DW-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev && is_req) begin
                checks++;
                if (out_tag !== hold_tag || out_data !== hold_data) begin
                    fails++;
                    $display("FAIL stall_hold: got tag %0d data %h, need tag %0d data %h",
                             out_tag, out_data, hold_tag, hold_data);
                end
            end
            if (is_req && !stall && !flush) begin
                checks++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL grant_unexpected: got tag %0d, need no request", out_tag);
                end else begin
                    fu_result_t e;
                    e = sbq.pop_front();
                    if (out_tag !== e.tag || out_data !== e.data) begin
                        fails++;
                        $display("FAIL grant_head: got tag %0d data %h, need tag %0d data %h",
                                 out_tag, out_data, e.tag, e.data);
                    end
                end
            end
            hold_prev = is_req && stall && !flush;
            hold_tag  = out_tag;
            hold_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // A refused push must not disturb the entry at the write pointer.
    logic       ovw_armed = 1'b0;
    fu_result_t ovw_snap;
    logic [1:0] ovw_idx;

    always @(negedge clk) begin
        ovw_armed = !rst && in_valid && !in_ready && !flush;
        ovw_idx   = dut.wr_ptr;
        ovw_snap  = dut.mem[dut.wr_ptr];
    end

    always @(posedge clk) begin
        #1;
        if (ovw_armed && !rst) begin
            checks++;
            if (dut.mem[ovw_idx] !== ovw_snap) begin
                fails++;
                $display("FAIL no_overwrite: got %h, need %h", dut.mem[ovw_idx], ovw_snap);
            end
        end
    end

    // One cycle of stimulus. acc: the bench expects the result to be taken.
    // exp_req/exp_rdy/exp_cnt: values during this cycle, before the edge.
    task automatic step(input logic v, input logic [TW-1:0] t, input logic st,
                        input logic fl, input logic acc, input logic exp_req,
                        input logic exp_rdy, input int exp_cnt);
        in_valid = v;
        in_tag   = t;
        in_data  = data_of(t);
        stall    = st;
        flush    = fl;
        if (fl) sbq.delete();
        if (acc) sbq.push_back('{data: data_of(t), tag: t});
        #3;
        checks++;
        if (is_req !== exp_req) begin
            fails++;
            $display("FAIL is_req: got %b, need %b (t=%0t)", is_req, exp_req, $time);
        end
        checks++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL in_ready: got %b, need %b (t=%0t)", in_ready, exp_rdy, $time);
        end
        checks++;
        if (int'(dut.count) != exp_cnt) begin
            fails++;
            $display("FAIL count: got %0d, need %0d (t=%0t)", dut.count, exp_cnt, $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st, input logic exp_req, input logic exp_rdy,
                        input int exp_cnt);
        step(1'b0, '0, st, 1'b0, 1'b0, exp_req, exp_rdy, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        repeat (5) idle(1'b0, 1'b0, 1'b1, 0);

        // Push 1,2,3 back to back, unstalled
        step(1'b1, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        step(1'b1, 6'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        idle(1'b0, 1'b1, 1'b1, 1);
        idle(1'b0, 1'b0, 1'b1, 0);

        // Fill under stall, then release
        step(1'b1, 6'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 6'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        step(1'b1, 6'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        step(1'b1, 6'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        idle(1'b1, 1'b1, 1'b0, 4);
        idle(1'b0, 1'b1, 1'b0, 4);
        idle(1'b0, 1'b1, 1'b1, 3);
        idle(1'b0, 1'b1, 1'b1, 2);
        idle(1'b0, 1'b1, 1'b1, 1);
        idle(1'b0, 1'b0, 1'b1, 0);

        // Full queue: push refused on the grant cycle, accepted next cycle
        step(1'b1, 6'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        step(1'b1, 6'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        step(1'b1, 6'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        step(1'b1, 6'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        step(1'b1, 6'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        idle(1'b1, 1'b1, 1'b0, 4);
        idle(1'b0, 1'b1, 1'b0, 4);
        idle(1'b0, 1'b1, 1'b1, 3);
        idle(1'b0, 1'b1, 1'b1, 2);
        idle(1'b0, 1'b1, 1'b1, 1);
        idle(1'b0, 1'b0, 1'b1, 0);

        // Flush with a concurrent push; the push is lost
        step(1'b1, 6'd21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 6'd22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        step(1'b1, 6'd23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        step(1'b1, 6'd24, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        idle(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle(1'b0, 1'b1, 1'b1, 1);
        idle(1'b0, 1'b0, 1'b1, 0);

        // Asynchronous reset mid-cycle with two entries held
        step(1'b1, 6'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, 6'd32, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        in_valid = 1'b0;
        #1;
        checks++;
        if (is_req !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_req: got %b, need 1", is_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (is_req !== 1'b0 || in_ready !== 1'b1 || dut.count !== 3'd0) begin
            fails++;
            $display("FAIL async_reset: got req %b rdy %b cnt %0d, need 0 1 0",
                     is_req, in_ready, dut.count);
        end
        sbq.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(1'b0, 1'b0, 1'b1, 0);

`ifdef FU_RESULT_QUEUE_BYPASS_EN
        // Same-cycle bypass, then stalled bypass that is written normally
        step(1'b1, 6'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle(1'b0, 1'b1, 1'b1, 1);
        idle(1'b0, 1'b0, 1'b1, 0);
`endif

        checks++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drained: got %0d results outstanding, need 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
